// File: rtl/div_pkg.sv
// div_pkg: shared encodings, FSM states and constants for the radix-2 divider
// Exports: OP_DIV/OP_DIVU/OP_REM/OP_REMU (operation[1] selects remainder, operation[0] selects unsigned),
//          div_state_t, DIV_ITER, DIV_OVF_DIVIDEND
package div_pkg;
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} div_state_t;
  localparam int DIV_ITER = 32;
  localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;
endpackage

// File: rtl/div_radix2_seq_step.sv
// div_step: one combinational restoring-division iteration
// Ports: rem [length:0] partial remainder, quo [length-1:0] dividend/quotient shift register,
//        divisor [length-1:0] divisor magnitude, rem_n/quo_n next-iteration values
module div_step import div_pkg::*; #(
  parameter int length = 32
) (
  input  logic [length:0]   rem,
  input  logic [length-1:0] quo,
  input  logic [length-1:0] divisor,
  output logic [length:0]   rem_n,
  output logic [length-1:0] quo_n
);
  logic [length+1:0] w_sh;
  logic [length+1:0] w_trial;
  // rem < divisor holds between steps, so the shifted value fits and the top bit of the trial is the borrow
  assign w_sh    = {rem, quo[length-1]};
  assign w_trial = w_sh - {2'b0, divisor};
  assign rem_n   = w_trial[length+1] ? w_sh[length:0] : w_trial[length:0];
  assign quo_n   = {quo[length-2:0], ~w_trial[length+1]};
endmodule

// File: rtl/div_radix2_seq.sv
// div_radix2_seq: sequential RV32M DIV/DIVU/REM/REMU, restoring radix-2, one quotient bit per clock
// Ports: clk, rst_n (async active-low), enable_div (start, sampled in IDLE), operation (funct3[1:0]),
//        dividend, divisor, div_o (held result), div_finish (one-cycle valid pulse), div_busy (CALC/FIX)
// Build option: define DIV_EARLY_TERM_EN to bypass CALC when |dividend| < |divisor|
module div_radix2_seq import div_pkg::*; #(
  parameter int length = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_div,
  input  logic [1:0]        operation,
  input  logic [length-1:0] dividend,
  input  logic [length-1:0] divisor,
  output logic [length-1:0] div_o,
  output logic              div_finish,
  output logic              div_busy
);
  div_state_t        r_state;
  logic [1:0]        r_op;
  logic [length:0]   r_rem;
  logic [length-1:0] r_quo;
  logic [length-1:0] r_dvs;
  logic              r_qneg;
  logic              r_rneg;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_a_neg, w_b_neg, w_dz, w_ovf;
  logic [length-1:0] w_a_mag, w_b_mag, w_q_fix, w_r_fix;
  logic [length:0]   w_rem_n;
  logic [length-1:0] w_quo_n;
  // operation[0]=1 means unsigned, so 0xFFFFFFFF is never negative there
  assign w_a_neg = ~operation[0] & dividend[length-1];
  assign w_b_neg = ~operation[0] & divisor[length-1];
  assign w_a_mag = w_a_neg ? -dividend : dividend;
  assign w_b_mag = w_b_neg ? -divisor : divisor;
  assign w_dz    = divisor == '0;
  assign w_ovf   = ~operation[0] && dividend == DIV_OVF_DIVIDEND && divisor == '1;
  assign w_q_fix = r_qneg ? -r_quo : r_quo;
  assign w_r_fix = r_rneg ? -r_rem[length-1:0] : r_rem[length-1:0];
`ifdef DIV_EARLY_TERM_EN
  logic w_early;
  assign w_early = w_a_mag < w_b_mag;
`endif
  div_step #(.length(length)) u_step (
    .rem(r_rem), .quo(r_quo), .divisor(r_dvs), .rem_n(w_rem_n), .quo_n(w_quo_n)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_op       <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_dvs      <= '0;
      r_qneg     <= 1'b0;
      r_rneg     <= 1'b0;
      r_cnt      <= '0;
      div_o      <= '0;
      div_finish <= 1'b0;
      div_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (enable_div) begin
          r_op   <= operation;
          r_dvs  <= w_b_mag;
          r_qneg <= w_a_neg ^ w_b_neg;
          r_rneg <= w_a_neg;
          r_cnt  <= '0;
          if (w_dz || w_ovf) begin
            div_o      <= w_dz ? (operation[1] ? dividend : '1) : (operation[1] ? '0 : DIV_OVF_DIVIDEND);
            div_finish <= 1'b1;
            r_state    <= S_DONE;
          end
`ifdef DIV_EARLY_TERM_EN
          else if (w_early) begin
            r_quo    <= '0;
            r_rem    <= {1'b0, w_a_mag};
            div_busy <= 1'b1;
            r_state  <= S_FIX;
          end
`endif
          else begin
            r_quo    <= w_a_mag;
            r_rem    <= '0;
            div_busy <= 1'b1;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          r_rem   <= w_rem_n;
          r_quo   <= w_quo_n;
          r_cnt   <= r_cnt + 1'b1;
          r_state <= r_cnt == CNT_W'(DIV_ITER - 1) ? S_FIX : S_CALC;
        end
        S_FIX: begin
          div_o      <= r_op[1] ? w_r_fix : w_q_fix;
          div_busy   <= 1'b0;
          div_finish <= 1'b1;
          r_state    <= S_DONE;
        end
        default: begin
          div_finish <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_div_radix2_seq.sv
// tb_div_radix2_seq: directed and random checks of div_radix2_seq against an arithmetic reference
module tb_div_radix2_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable_div = 1'b0;
  logic [1:0]  operation = 2'b00;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [31:0] div_o;
  logic        div_finish;
  logic        div_busy;
  int total = 0;
  int bad = 0;
  div_radix2_seq dut (
    .clk(clk), .rst_n(rst_n), .enable_div(enable_div), .operation(operation),
    .dividend(dividend), .divisor(divisor), .div_o(div_o), .div_finish(div_finish), .div_busy(div_busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (op[0]) return op[1] ? a % b : a / b;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    return op[1] ? 32'(sa % sb) : 32'(sa / sb);
  endfunction
  function automatic logic [31:0] mag(input logic [1:0] op, input logic [31:0] v);
    return (!op[0] && v[31]) ? -v : v;
  endfunction
  // edges after the start edge until div_finish is first seen high
  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 0;
`ifdef DIV_EARLY_TERM_EN
    if (mag(op, a) < mag(op, b)) return 1;
`endif
    return 33;
  endfunction
  task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp_v;
    int exp_l, k, nbusy;
    exp_v = ref_res(op, a, b);
    exp_l = ref_lat(op, a, b);
    k = 0;
    nbusy = 0;
    operation = op;
    dividend = a;
    divisor = b;
    enable_div = 1'b1;
    @(posedge clk); #1;
    enable_div = 1'b0;
    operation = 2'($urandom);
    dividend = $urandom;
    divisor = $urandom;
    while (!div_finish && k < 40) begin
      nbusy += int'(div_busy);
      k++;
      @(posedge clk); #1;
    end
    check({tag, " latency"}, 32'(k), 32'(exp_l));
    check({tag, " busy_cycles"}, 32'(nbusy), 32'(exp_l));
    check({tag, " result"}, div_o, exp_v);
    @(posedge clk); #1;
    check({tag, " finish_pulse"}, {31'b0, div_finish}, 32'd0);
    check({tag, " busy_after"}, {31'b0, div_busy}, 32'd0);
    check({tag, " hold"}, div_o, exp_v);
  endtask
  initial begin
    int nfin;
    logic [31:0] a, b;
    logic [1:0] op;
    repeat (2) @(posedge clk);
    #1;
    check("reset div_o", div_o, 32'd0);
    check("reset finish", {31'b0, div_finish}, 32'd0);
    check("reset busy", {31'b0, div_busy}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run("divu 100/7", 2'b01, 32'd100, 32'd7);
    run("remu 100/7", 2'b11, 32'd100, 32'd7);
    run("div -100/7", 2'b00, 32'hFFFF_FF9C, 32'd7);
    run("rem -100/7", 2'b10, 32'hFFFF_FF9C, 32'd7);
    run("rem 100/-7", 2'b10, 32'd100, 32'hFFFF_FFF9);
    run("div 5/0", 2'b00, 32'd5, 32'd0);
    run("remu 5/0", 2'b11, 32'd5, 32'd0);
    run("div ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    run("rem ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run("divu ovf operands", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
    run("divu 3/10", 2'b01, 32'd3, 32'd10);
    run("remu 3/10", 2'b11, 32'd3, 32'd10);
    run("divu max/3", 2'b01, 32'hFFFF_FFFF, 32'd3);
    operation = 2'b01;
    dividend = 32'hFFFF_FFFF;
    divisor = 32'd1;
    enable_div = 1'b1;
    @(posedge clk); #1;
    enable_div = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    operation = 2'b00;
    dividend = 32'd7;
    divisor = 32'd2;
    enable_div = 1'b1;
    @(posedge clk); #1;
    enable_div = 1'b0;
    check("abort busy at E10", {31'b0, div_busy}, 32'd1);
    check("abort no finish at E10", {31'b0, div_finish}, 32'd0);
    repeat (9) @(posedge clk);
    #1;
    check("abort busy before reset", {31'b0, div_busy}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort div_o", div_o, 32'd0);
    check("abort finish", {31'b0, div_finish}, 32'd0);
    check("abort busy", {31'b0, div_busy}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    nfin = 0;
    repeat (40) begin
      @(posedge clk); #1;
      nfin += int'(div_finish);
    end
    check("abort no finish after", 32'(nfin), 32'd0);
    run("after abort divu 0xffffffff/1", 2'b01, 32'hFFFF_FFFF, 32'd1);
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      a = $urandom;
      b = (i % 4 == 0) ? 32'($urandom_range(0, 15)) : (i % 4 == 1) ? -32'($urandom_range(1, 300)) : $urandom;
      if (i % 10 == 7) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      run("random", op, a, b);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
